// File: rtl/k2red_mul_src.sv
// k2red_mul_src: sequential radix-2 shift-add multiplier, A = X*Y over valid/ready (optional operand pre-reduction under MUL_OPREDUCE_EN)
module k2red_mul_src #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
`ifdef MUL_OPREDUCE_EN
  input  logic [W-1:0]   Q,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] A,
  output logic           busy
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] WC = CW'(W);
`ifdef MUL_OPREDUCE_EN
  typedef enum logic [1:0] {IDLE, PRE, RUN, DONE} state_t;
  logic [W-1:0] qr;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
  state_t st;
  logic [W-1:0]   xr, yr;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [W:0]     sum;
  // upper accumulator half plus the multiplicand when the current multiplier bit is set, carry kept
  always_comb sum = {1'b0, acc[2*W-1:W]} + (yr[0] ? {1'b0, xr} : '0);
  // control FSM and datapath; all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      xr        <= '0;
      yr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      A         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef MUL_OPREDUCE_EN
      qr        <= '0;
`endif
    end else begin
      case (st)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            xr       <= X;
            yr       <= Y;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef MUL_OPREDUCE_EN
            qr       <= Q;
            st       <= PRE;
`else
            st       <= RUN;
`endif
          end
        end
`ifdef MUL_OPREDUCE_EN
        PRE: begin
          xr <= xr >= qr ? xr - qr : xr;
          yr <= yr >= qr ? yr - qr : yr;
          st <= RUN;
        end
`endif
        RUN: begin
          if (cnt == WC) begin
            A         <= acc;
            out_valid <= 1'b1;
            st        <= DONE;
          end else begin
            acc <= {sum, acc[W-1:1]};
            yr  <= yr >> 1;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_k2red_mul_src.sv
// tb_k2red_mul_src: randomized scoreboard bench for k2red_mul_src (honours MUL_OPREDUCE_EN)
module tb_k2red_mul_src;
  localparam int W = 32;
`ifdef MUL_OPREDUCE_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [W-1:0] X = '0, Y = '0;
  logic [W-1:0] Q = 32'hC0000001;
  logic [2*W-1:0] A;
  int n_chk = 0, n_fail = 0, cyc = 0, n_acc = 0, last_acc = 0, prev_acc = 0;
  logic [63:0] exp_q[$];
  int acc_q[$];
  logic prev_ov = 1'b0;
  logic [63:0] prev_a = '0;
  logic rnd_rdy = 1'b0;

  k2red_mul_src #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
`ifdef MUL_OPREDUCE_EN
    .Q(Q),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] q);
    longint unsigned xv, yv;
    xv = x;
    yv = y;
`ifdef MUL_OPREDUCE_EN
    if (xv >= q) xv = xv - q;
    if (yv >= q) yv = yv - q;
`endif
    return xv * yv;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // edge counter and stimulus-side scoreboard push on every accepting edge
  always @(posedge clk) begin
    cyc++;
    if (rst && in_valid && in_ready) begin
      exp_q.push_back(model(X, Y, Q));
      acc_q.push_back(cyc);
      prev_acc = last_acc;
      last_acc = cyc;
      n_acc++;
    end
  end

  // random downstream backpressure when enabled
  always @(posedge clk) if (rnd_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  // monitor: latency on rise, stability while held, product on handoff
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - acc_q.pop_front()), 64'(LAT));
      end
      if (out_valid) chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
      if (prev_ov && out_valid) chk("hold_A", A, prev_a);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_product", 64'd1, 64'd0);
        else chk("product", A, exp_q.pop_front());
      end
      prev_ov = out_valid;
      prev_a = A;
    end else prev_ov = 1'b0;
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int n0, t;
    n0 = n_acc;
    t = 0;
    in_valid = 1'b1;
    X = x;
    Y = y;
    while (n_acc == n0 && t < 400) begin
      @(posedge clk);
      #1 t++;
    end
    if (n_acc == n0) chk("accept_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
    X = $urandom;
    Y = $urandom;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      #1 t++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_A", A, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    send(32'd3, 32'd5);
    wait_drain();
    send(32'hFFFFFFFF, 32'hFFFFFFFF);
    send(32'd0, 32'hDEADBEEF);
    wait_drain();
    out_ready = 1'b0;
    send(32'h12345678, 32'h9ABCDEF0);
    for (int t = 0; t < 200 && !out_valid; t++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_A", A, 64'h0B00EA4E242D2080);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    wait_drain();
    in_valid = 1'b1;
    X = 32'hA5A5A5A5;
    Y = 32'h0000F00D;
    send(32'hA5A5A5A5, 32'h0000F00D);
    send(32'h13579BDF, 32'h2468ACE0);
    chk("b2b_spacing", 64'(last_acc - prev_acc), 64'(LAT + 2));
    wait_drain();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 12; i++) send($urandom, (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom);
    wait_drain();
    rnd_rdy = 1'b0;
    #2 out_ready = 1'b1;
    send($urandom, $urandom);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_A", A, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk) rst = 1'b1;
    send(32'd7, 32'd9);
    wait_drain();
    repeat (5) @(posedge clk);
`ifdef MUL_OPREDUCE_EN
    send(32'hC0000005, 32'd2);
    for (int t = 0; t < 200 && !out_valid; t++) @(posedge clk);
    #1 chk("opreduce_A", A, 64'd8);
    wait_drain();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
